// File: rtl/mips16_pkg.sv
// Shared definitions for the 16-bit single-cycle MIPS-style CPU.
// Contents: datapath widths, memory depths, opcode and function encodings,
// ALU operation codes, the decoded-control bundle and the multiplier state type.
package mips16_pkg;
   localparam int DATA_W     = 16;
   localparam int INSTR_W    = 32;
   localparam int PC_W       = 8;
   localparam int NREGS      = 32;
   localparam int IMEM_DEPTH = 256;
   localparam int DMEM_DEPTH = 256;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'b000,
      ALU_SUB  = 3'b001,
      ALU_AND  = 3'b010,
      ALU_OR   = 3'b011,
      ALU_SLT  = 3'b100,
      ALU_MULT = 3'b101
   } alu_op_e;

   typedef struct packed {
      alu_op_e alu_op;
      logic    mem_to_reg;
      logic    mem_write_en;
      logic    reg_write_en;
      logic    imm_sl;
      logic    br_sl;
      logic    breq_sl;
      logic    reg_dest;
      logic    jump_sl;
      logic    jump_reg_sl;
      logic    mult_sl;
      logic    mf_sl;
      logic    hi_lo_sl;
   } ctrl_t;

   typedef enum logic {
      MULT_IDLE = 1'b0,
      MULT_BUSY = 1'b1
   } mult_state_e;

   // Branch target PC+1+offset; only the low byte of the offset matters since the PC wraps at 8 bits
   function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0] pc,
                                                     input logic [PC_W-1:0] off);
      return pc + 8'd1 + off;
   endfunction
endpackage

// File: rtl/mips16_control.sv
// Instruction decoder: turns opcode/function fields into the datapath control bundle.
// Ports: i_op (instr[31:26]), i_func (instr[5:0]), o_ctrl (decoded controls).
// Unknown encodings decode to an all-zero bundle, i.e. a NOP with no writes.
module mips16_control
   import mips16_pkg::*;
(
   input  logic [5:0] i_op,
   input  logic [5:0] i_func,
   output ctrl_t      o_ctrl
);
   // Opcode / function decode with NOP defaults
   always_comb begin
      o_ctrl        = '0;
      o_ctrl.alu_op = ALU_ADD;
      case (i_op)
         OP_RTYPE: begin
            o_ctrl.reg_dest = 1'b1;
            case (i_func)
               FN_ADD:  o_ctrl.reg_write_en = 1'b1;
               FN_SUB:  begin o_ctrl.reg_write_en = 1'b1; o_ctrl.alu_op = ALU_SUB; end
               FN_AND:  begin o_ctrl.reg_write_en = 1'b1; o_ctrl.alu_op = ALU_AND; end
               FN_OR:   begin o_ctrl.reg_write_en = 1'b1; o_ctrl.alu_op = ALU_OR;  end
               FN_SLT:  begin o_ctrl.reg_write_en = 1'b1; o_ctrl.alu_op = ALU_SLT; end
               FN_JR:   o_ctrl.jump_reg_sl = 1'b1;
               FN_MULT: begin o_ctrl.mult_sl = 1'b1; o_ctrl.alu_op = ALU_MULT; end
               FN_MFHI: begin o_ctrl.reg_write_en = 1'b1; o_ctrl.mf_sl = 1'b1; o_ctrl.hi_lo_sl = 1'b1; end
               FN_MFLO: begin o_ctrl.reg_write_en = 1'b1; o_ctrl.mf_sl = 1'b1; end
               default: o_ctrl.reg_write_en = 1'b0;
            endcase
         end
         OP_ADDI: begin o_ctrl.imm_sl = 1'b1; o_ctrl.reg_write_en = 1'b1; end
         OP_LW:   begin o_ctrl.imm_sl = 1'b1; o_ctrl.reg_write_en = 1'b1; o_ctrl.mem_to_reg = 1'b1; end
         OP_SW:   begin o_ctrl.imm_sl = 1'b1; o_ctrl.mem_write_en = 1'b1; end
         OP_BEQ:  begin o_ctrl.br_sl = 1'b1; o_ctrl.breq_sl = 1'b1; o_ctrl.alu_op = ALU_SUB; end
         OP_BNE:  begin o_ctrl.br_sl = 1'b1; o_ctrl.alu_op = ALU_SUB; end
         OP_J:    o_ctrl.jump_sl = 1'b1;
         default: o_ctrl.reg_write_en = 1'b0;
      endcase
   end
endmodule

// File: rtl/mips16_datapath.sv
// Datapath: PC, instruction memory, register file, ALU, data memory, write-back,
// next-PC selection and the iterative signed 16x16 multiplier with HI/LO.
// Ports: i_clk, i_rst (sync), i_ctrl (decoded controls); o_instr (IMEM[PC]), o_alu_result,
// o_rdata_a/b (rs/rt values), o_alu_reset (mult issue), o_stall (PC hold), o_ready (mult done).
module mips16_datapath
   import mips16_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  ctrl_t              i_ctrl,
   output logic [INSTR_W-1:0] o_instr,
   output logic [DATA_W-1:0]  o_alu_result,
   output logic [DATA_W-1:0]  o_rdata_a,
   output logic [DATA_W-1:0]  o_rdata_b,
   output logic               o_alu_reset,
   output logic               o_stall,
   output logic               o_ready
);
   logic [INSTR_W-1:0] r_imem [IMEM_DEPTH];
   logic [PC_W-1:0]    r_pc, w_pc_next;
   logic [DATA_W-1:0]  w_alu_b, w_alu, w_mem_rdata, w_wb_data;
   logic [4:0]         w_waddr;
   logic               w_taken;
   mult_state_e        r_state, w_state_next;
   logic [3:0]         r_cnt;
   logic [31:0]        r_mcand, r_acc, w_addend, w_acc_next;
   logic [DATA_W-1:0]  r_mplier, r_hi, r_lo;

   assign o_instr      = r_imem[r_pc];
   assign w_alu_b      = i_ctrl.imm_sl ? o_instr[15:0] : o_rdata_b;
   assign w_waddr      = i_ctrl.reg_dest ? o_instr[15:11] : o_instr[20:16];
   assign w_taken      = i_ctrl.br_sl & (i_ctrl.breq_sl ? (o_rdata_a == o_rdata_b)
                                                        : (o_rdata_a != o_rdata_b));
   assign o_alu_result = w_alu;

   mips16_regfile instruction_registers (
      .i_clk(i_clk), .i_rst(i_rst), .i_we(i_ctrl.reg_write_en), .i_waddr(w_waddr),
      .i_wdata(w_wb_data), .i_raddr_a(o_instr[25:21]), .i_raddr_b(o_instr[20:16]),
      .o_rdata_a(o_rdata_a), .o_rdata_b(o_rdata_b));

   mips16_dmem data_registers (
      .i_clk(i_clk), .i_we(i_ctrl.mem_write_en & ~i_rst), .i_addr(w_alu[7:0]),
      .i_wdata(o_rdata_b), .o_rdata(w_mem_rdata));

   // ALU; the product comes from the iterative unit, so mult shows zero here
   always_comb begin
      w_alu = 16'd0;
      case (i_ctrl.alu_op)
         ALU_ADD: w_alu = o_rdata_a + w_alu_b;
         ALU_SUB: w_alu = o_rdata_a - w_alu_b;
         ALU_AND: w_alu = o_rdata_a & w_alu_b;
         ALU_OR:  w_alu = o_rdata_a | w_alu_b;
         ALU_SLT: w_alu = ($signed(o_rdata_a) < $signed(w_alu_b)) ? 16'd1 : 16'd0;
         default: w_alu = 16'd0;
      endcase
   end

   // Write-back source: load data, HI/LO move, or ALU result
   always_comb begin
      if (i_ctrl.mem_to_reg)  w_wb_data = w_mem_rdata;
      else if (i_ctrl.mf_sl)  w_wb_data = i_ctrl.hi_lo_sl ? r_hi : r_lo;
      else                    w_wb_data = w_alu;
   end

   // Next PC: stall hold > jr > j > taken branch > sequential
   always_comb begin
      if (o_stall)                 w_pc_next = r_pc;
      else if (i_ctrl.jump_reg_sl) w_pc_next = o_rdata_a[7:0];
      else if (i_ctrl.jump_sl)     w_pc_next = o_instr[7:0];
      else if (w_taken)            w_pc_next = branch_target(r_pc, o_instr[7:0]);
      else                         w_pc_next = r_pc + 8'd1;
   end

   // Program counter
   always_ff @(posedge i_clk) begin
      if (i_rst) r_pc <= 8'd0;
      else       r_pc <= w_pc_next;
   end

   // Multiplier control: issue cycle, then 16 step cycles with ready on the last
   always_comb begin
      w_state_next = r_state;
      o_alu_reset  = 1'b0;
      o_stall      = 1'b0;
      o_ready      = 1'b0;
      case (r_state)
         MULT_IDLE: begin
            if (i_ctrl.mult_sl) begin
               o_alu_reset  = 1'b1;
               o_stall      = 1'b1;
               w_state_next = MULT_BUSY;
            end else begin
               w_state_next = MULT_IDLE;
            end
         end
         MULT_BUSY: begin
            if (r_cnt == 4'd15) begin
               o_ready      = 1'b1;
               w_state_next = MULT_IDLE;
            end else begin
               o_stall      = 1'b1;
            end
         end
         default: w_state_next = MULT_IDLE;
      endcase
   end

   // Multiplier state register
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= MULT_IDLE;
      else       r_state <= w_state_next;
   end

   // Shift-add step; the multiplier MSB has negative weight in two's complement
   always_comb begin
      if (!r_mplier[r_cnt])     w_addend = 32'd0;
      else if (r_cnt == 4'd15)  w_addend = 32'd0 - r_mcand;
      else                      w_addend = r_mcand;
   end
   assign w_acc_next = r_acc + w_addend;

   // Multiplier operands, accumulator and HI/LO; reset aborts without touching HI/LO beyond clearing
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= 4'd0; r_mcand <= 32'd0; r_mplier <= 16'd0;
         r_acc <= 32'd0; r_hi <= 16'd0; r_lo <= 16'd0;
      end else if (o_alu_reset) begin
         r_cnt    <= 4'd0;
         r_mcand  <= {{16{o_rdata_a[15]}}, o_rdata_a};
         r_mplier <= o_rdata_b;
         r_acc    <= 32'd0;
      end else if (r_state == MULT_BUSY) begin
         r_cnt   <= r_cnt + 4'd1;
         r_mcand <= r_mcand << 1;
         r_acc   <= w_acc_next;
         if (o_ready) {r_hi, r_lo} <= w_acc_next;
      end
   end
endmodule

// File: rtl/mips16_dmem.sv
// Data memory: 256 x 16-bit, combinational read, write on rising edge. Not cleared by reset.
// Ports: i_clk, i_we, i_addr (word address), i_wdata, o_rdata.
module mips16_dmem
   import mips16_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [7:0]        i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);
   logic [DATA_W-1:0] register [DMEM_DEPTH];

   // Store port
   always_ff @(posedge i_clk) begin
      if (i_we) register[i_addr] <= i_wdata;
   end

   assign o_rdata = register[i_addr];
endmodule

// File: rtl/mips16_regfile.sv
// General register file: 32 x 16-bit, two combinational read ports, one write port.
// Ports: i_clk, i_rst (sync, clears all), i_we/i_waddr/i_wdata, i_raddr_a/b -> o_rdata_a/b.
// $0 always reads zero and ignores writes.
module mips16_regfile
   import mips16_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_we,
   input  logic [4:0]        i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [4:0]        i_raddr_a,
   input  logic [4:0]        i_raddr_b,
   output logic [DATA_W-1:0] o_rdata_a,
   output logic [DATA_W-1:0] o_rdata_b
);
   logic [DATA_W-1:0] register [NREGS];

   // Synchronous clear on reset, otherwise write-back to any register but $0
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < NREGS; i++) register[i] <= 16'd0;
      end else if (i_we && (i_waddr != 5'd0)) begin
         register[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = (i_raddr_a == 5'd0) ? 16'd0 : register[i_raddr_a];
   assign o_rdata_b = (i_raddr_b == 5'd0) ? 16'd0 : register[i_raddr_b];
endmodule

// File: rtl/mips16_single_cycle_cpu.sv
// Top of the single-cycle 16-bit MIPS-style CPU. Exposes decoded controls and datapath values.
// Ports: clock, reset (sync active-high); out (ALU result), instruction (IMEM word),
// op_code_out/func_out, alu_op_out, reg_data_out_a/b, and one-bit control/status observers.
module mips16_single_cycle_cpu
   import mips16_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   output logic [15:0] out,
   output logic [31:0] instruction,
   output logic [5:0]  op_code_out,
   output logic [5:0]  func_out,
   output logic [2:0]  alu_op_out,
   output logic [15:0] reg_data_out_a,
   output logic [15:0] reg_data_out_b,
   output logic        mem_to_reg_out,
   output logic        mem_write_en_out,
   output logic        reg_write_en_out,
   output logic        imm_sl_out,
   output logic        br_sl_out,
   output logic        breq_sl_out,
   output logic        reg_dest_out,
   output logic        jump_sl_out,
   output logic        jump_reg_sl_out,
   output logic        alu_reset_out,
   output logic        instr_stall_sl_out,
   output logic        ready_out,
   output logic        hi_lo_sl_out
);
   ctrl_t w_ctrl;

   mips16_control u_control (
      .i_op(instruction[31:26]), .i_func(instruction[5:0]), .o_ctrl(w_ctrl));

   mips16_datapath d1 (
      .i_clk(clock), .i_rst(reset), .i_ctrl(w_ctrl), .o_instr(instruction),
      .o_alu_result(out), .o_rdata_a(reg_data_out_a), .o_rdata_b(reg_data_out_b),
      .o_alu_reset(alu_reset_out), .o_stall(instr_stall_sl_out), .o_ready(ready_out));

   assign op_code_out      = instruction[31:26];
   assign func_out         = instruction[5:0];
   assign alu_op_out       = w_ctrl.alu_op;
   assign mem_to_reg_out   = w_ctrl.mem_to_reg;
   assign mem_write_en_out = w_ctrl.mem_write_en;
   assign reg_write_en_out = w_ctrl.reg_write_en;
   assign imm_sl_out       = w_ctrl.imm_sl;
   assign br_sl_out        = w_ctrl.br_sl;
   assign breq_sl_out      = w_ctrl.breq_sl;
   assign reg_dest_out     = w_ctrl.reg_dest;
   assign jump_sl_out      = w_ctrl.jump_sl;
   assign jump_reg_sl_out  = w_ctrl.jump_reg_sl;
   assign hi_lo_sl_out     = w_ctrl.hi_lo_sl;
endmodule

// File: tb/tb_mips16_single_cycle_cpu.sv
// Directed testbench for mips16_single_cycle_cpu: small programs written into IMEM,
// architectural state observed through the d1 hierarchy after each clock edge.
module tb_mips16_single_cycle_cpu;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] out;
   logic [31:0] instruction;
   logic [5:0]  op_code_out, func_out;
   logic [2:0]  alu_op_out;
   logic [15:0] reg_data_out_a, reg_data_out_b;
   logic mem_to_reg_out, mem_write_en_out, reg_write_en_out, imm_sl_out, br_sl_out;
   logic breq_sl_out, reg_dest_out, jump_sl_out, jump_reg_sl_out, alu_reset_out;
   logic instr_stall_sl_out, ready_out, hi_lo_sl_out;

   int checks = 0;
   int failures = 0;

   mips16_single_cycle_cpu dut (
      .clock(clock), .reset(reset), .out(out), .instruction(instruction),
      .op_code_out(op_code_out), .func_out(func_out), .alu_op_out(alu_op_out),
      .reg_data_out_a(reg_data_out_a), .reg_data_out_b(reg_data_out_b),
      .mem_to_reg_out(mem_to_reg_out), .mem_write_en_out(mem_write_en_out),
      .reg_write_en_out(reg_write_en_out), .imm_sl_out(imm_sl_out), .br_sl_out(br_sl_out),
      .breq_sl_out(breq_sl_out), .reg_dest_out(reg_dest_out), .jump_sl_out(jump_sl_out),
      .jump_reg_sl_out(jump_reg_sl_out), .alu_reset_out(alu_reset_out),
      .instr_stall_sl_out(instr_stall_sl_out), .ready_out(ready_out),
      .hi_lo_sl_out(hi_lo_sl_out));

   always #5 clock = ~clock;

   function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_imem();
      for (int k = 0; k < 256; k++) dut.d1.r_imem[k] = 32'd0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      clear_imem();
      dut.d1.r_imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd9);
      do_reset();
      checks++; if (dut.d1.r_pc !== 8'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", dut.d1.r_pc); end
      checks++; if (dut.d1.instruction_registers.register[1] !== 16'd0) begin failures++; $display("FAIL reset_reg1 got=%0h exp=0", dut.d1.instruction_registers.register[1]); end
      checks++; if ({dut.d1.r_hi, dut.d1.r_lo} !== 32'd0) begin failures++; $display("FAIL reset_hilo got=%0h exp=0", {dut.d1.r_hi, dut.d1.r_lo}); end
      checks++; if ({instr_stall_sl_out, ready_out} !== 2'b00) begin failures++; $display("FAIL reset_stall_ready got=%b exp=00", {instr_stall_sl_out, ready_out}); end
      checks++; if (instruction !== 32'h2001_0009) begin failures++; $display("FAIL reset_fetch got=%h exp=20010009", instruction); end
      checks++; if ({op_code_out, imm_sl_out, reg_write_en_out, out} !== {6'h08, 1'b1, 1'b1, 16'd9}) begin failures++; $display("FAIL addi_decode got=%h exp=%h", {op_code_out, imm_sl_out, reg_write_en_out, out}, {6'h08, 1'b1, 1'b1, 16'd9}); end
   endtask

   task automatic test_sub();
      clear_imem();
      dut.d1.r_imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd9);
      dut.d1.r_imem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd4);
      dut.d1.r_imem[2] = enc_r(6'h22, 5'd1, 5'd2, 5'd3);
      do_reset();
      tick();
      tick();
      checks++; if ({out, alu_op_out, reg_dest_out, func_out} !== {16'd5, 3'b001, 1'b1, 6'h22}) begin failures++; $display("FAIL sub_decode got=%h exp=%h", {out, alu_op_out, reg_dest_out, func_out}, {16'd5, 3'b001, 1'b1, 6'h22}); end
      tick();
      checks++; if (dut.d1.instruction_registers.register[3] !== 16'd5) begin failures++; $display("FAIL sub_r3 got=%0d exp=5", dut.d1.instruction_registers.register[3]); end
      checks++; if ({dut.d1.instruction_registers.register[1], dut.d1.instruction_registers.register[2]} !== {16'd9, 16'd4}) begin failures++; $display("FAIL sub_r1r2 got=%h exp=00090004", {dut.d1.instruction_registers.register[1], dut.d1.instruction_registers.register[2]}); end
   endtask

   task automatic test_lw_sw();
      clear_imem();
      dut.d1.r_imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd7);
      dut.d1.r_imem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'd3);
      dut.d1.r_imem[2] = enc_i(6'h23, 5'd0, 5'd4, 16'd3);
      do_reset();
      checks++; if (mem_write_en_out !== 1'b0) begin failures++; $display("FAIL lw_sw_we0 got=%b exp=0", mem_write_en_out); end
      tick();
      checks++; if ({mem_write_en_out, reg_write_en_out, out} !== {1'b1, 1'b0, 16'd3}) begin failures++; $display("FAIL sw_cycle got=%h exp=%h", {mem_write_en_out, reg_write_en_out, out}, {1'b1, 1'b0, 16'd3}); end
      tick();
      checks++; if ({mem_write_en_out, mem_to_reg_out} !== 2'b01) begin failures++; $display("FAIL lw_cycle got=%b exp=01", {mem_write_en_out, mem_to_reg_out}); end
      checks++; if (dut.d1.data_registers.register[3] !== 16'd7) begin failures++; $display("FAIL dmem3 got=%0d exp=7", dut.d1.data_registers.register[3]); end
      tick();
      checks++; if (dut.d1.instruction_registers.register[4] !== 16'd7) begin failures++; $display("FAIL lw_r4 got=%0d exp=7", dut.d1.instruction_registers.register[4]); end
   endtask

   task automatic test_branch();
      clear_imem();
      dut.d1.r_imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
      dut.d1.r_imem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd3);
      dut.d1.r_imem[2] = enc_i(6'h04, 5'd1, 5'd2, 16'd2);
      dut.d1.r_imem[3] = enc_i(6'h08, 5'd0, 5'd6, 16'd1);
      dut.d1.r_imem[4] = enc_i(6'h08, 5'd0, 5'd6, 16'd2);
      dut.d1.r_imem[5] = enc_i(6'h05, 5'd1, 5'd2, 16'd2);
      dut.d1.r_imem[6] = enc_i(6'h08, 5'd0, 5'd7, 16'd8);
      do_reset();
      tick();
      tick();
      checks++; if ({br_sl_out, breq_sl_out} !== 2'b11) begin failures++; $display("FAIL beq_decode got=%b exp=11", {br_sl_out, breq_sl_out}); end
      tick();
      checks++; if (dut.d1.r_pc !== 8'd5) begin failures++; $display("FAIL beq_taken_pc got=%0d exp=5", dut.d1.r_pc); end
      checks++; if ({br_sl_out, breq_sl_out} !== 2'b10) begin failures++; $display("FAIL bne_decode got=%b exp=10", {br_sl_out, breq_sl_out}); end
      tick();
      checks++; if (dut.d1.r_pc !== 8'd6) begin failures++; $display("FAIL bne_fall_pc got=%0d exp=6", dut.d1.r_pc); end
      tick();
      checks++; if ({dut.d1.instruction_registers.register[6], dut.d1.instruction_registers.register[7]} !== {16'd0, 16'd8}) begin failures++; $display("FAIL branch_regs got=%h exp=00000008", {dut.d1.instruction_registers.register[6], dut.d1.instruction_registers.register[7]}); end
   endtask

   task automatic test_jump();
      clear_imem();
      dut.d1.r_imem[0] = enc_i(6'h08, 5'd0, 5'd5, 16'd9);
      dut.d1.r_imem[1] = {6'h02, 26'd5};
      dut.d1.r_imem[5] = enc_r(6'h08, 5'd5, 5'd0, 5'd0);
      dut.d1.r_imem[9] = enc_i(6'h08, 5'd0, 5'd8, 16'd4);
      do_reset();
      tick();
      checks++; if ({jump_sl_out, jump_reg_sl_out} !== 2'b10) begin failures++; $display("FAIL j_decode got=%b exp=10", {jump_sl_out, jump_reg_sl_out}); end
      tick();
      checks++; if (dut.d1.r_pc !== 8'd5) begin failures++; $display("FAIL j_pc got=%0d exp=5", dut.d1.r_pc); end
      checks++; if ({jump_sl_out, jump_reg_sl_out, reg_write_en_out} !== 3'b010) begin failures++; $display("FAIL jr_decode got=%b exp=010", {jump_sl_out, jump_reg_sl_out, reg_write_en_out}); end
      tick();
      checks++; if (dut.d1.r_pc !== 8'd9) begin failures++; $display("FAIL jr_pc got=%0d exp=9", dut.d1.r_pc); end
      tick();
      checks++; if (dut.d1.instruction_registers.register[8] !== 16'd4) begin failures++; $display("FAIL jump_r8 got=%0d exp=4", dut.d1.instruction_registers.register[8]); end
   endtask

   task automatic test_mult();
      int stall_cnt = 0;
      int ready_cnt = 0;
      int issue_cnt = 0;
      int pc_moved  = 0;
      clear_imem();
      dut.d1.r_imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd300);
      dut.d1.r_imem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd300);
      dut.d1.r_imem[2] = enc_r(6'h18, 5'd1, 5'd2, 5'd0);
      dut.d1.r_imem[3] = enc_r(6'h10, 5'd0, 5'd0, 5'd3);
      dut.d1.r_imem[4] = enc_r(6'h12, 5'd0, 5'd0, 5'd4);
      do_reset();
      tick();
      tick();
      checks++; if ({alu_reset_out, instr_stall_sl_out, alu_op_out, reg_write_en_out} !== {1'b1, 1'b1, 3'b101, 1'b0}) begin failures++; $display("FAIL mult_issue got=%b exp=111010", {alu_reset_out, instr_stall_sl_out, alu_op_out, reg_write_en_out}); end
      for (int i = 0; i < 17; i++) begin
         stall_cnt += int'(instr_stall_sl_out);
         ready_cnt += int'(ready_out);
         issue_cnt += int'(alu_reset_out);
         if (dut.d1.r_pc !== 8'd2) pc_moved++;
         tick();
      end
      checks++; if (stall_cnt !== 16) begin failures++; $display("FAIL mult_stall_cycles got=%0d exp=16", stall_cnt); end
      checks++; if ({ready_cnt, issue_cnt, pc_moved} !== {32'd1, 32'd1, 32'd0}) begin failures++; $display("FAIL mult_pulses ready=%0d issue=%0d pcmoves=%0d exp=1/1/0", ready_cnt, issue_cnt, pc_moved); end
      checks++; if (dut.d1.r_pc !== 8'd3) begin failures++; $display("FAIL mult_pc_after got=%0d exp=3", dut.d1.r_pc); end
      checks++; if ({dut.d1.r_hi, dut.d1.r_lo} !== {16'd1, 16'd24464}) begin failures++; $display("FAIL mult_hilo got=%0d/%0d exp=1/24464", dut.d1.r_hi, dut.d1.r_lo); end
      checks++; if ({ready_out, instr_stall_sl_out, hi_lo_sl_out} !== 3'b001) begin failures++; $display("FAIL mfhi_cycle got=%b exp=001", {ready_out, instr_stall_sl_out, hi_lo_sl_out}); end
      tick();
      checks++; if (hi_lo_sl_out !== 1'b0) begin failures++; $display("FAIL mflo_sel got=%b exp=0", hi_lo_sl_out); end
      tick();
      checks++; if ({dut.d1.instruction_registers.register[3], dut.d1.instruction_registers.register[4]} !== {16'd1, 16'd24464}) begin failures++; $display("FAIL mf_regs got=%0d/%0d exp=1/24464", dut.d1.instruction_registers.register[3], dut.d1.instruction_registers.register[4]); end
   endtask

   task automatic test_reset_mid_mult();
      clear_imem();
      dut.d1.r_imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd300);
      dut.d1.r_imem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd300);
      dut.d1.r_imem[2] = enc_r(6'h18, 5'd1, 5'd2, 5'd0);
      do_reset();
      repeat (7) tick();
      checks++; if (instr_stall_sl_out !== 1'b1) begin failures++; $display("FAIL midmult_busy got=%b exp=1", instr_stall_sl_out); end
      reset = 1'b1;
      tick();
      checks++; if ({dut.d1.r_pc, instr_stall_sl_out, ready_out} !== {8'd0, 1'b0, 1'b0}) begin failures++; $display("FAIL midmult_reset pc=%0d stall=%b ready=%b exp=0/0/0", dut.d1.r_pc, instr_stall_sl_out, ready_out); end
      checks++; if ({dut.d1.instruction_registers.register[1], dut.d1.r_hi, dut.d1.r_lo} !== 48'd0) begin failures++; $display("FAIL midmult_regs got=%h exp=0", {dut.d1.instruction_registers.register[1], dut.d1.r_hi, dut.d1.r_lo}); end
      reset = 1'b0;
   endtask

   task automatic test_zero_slt();
      clear_imem();
      dut.d1.r_imem[0] = enc_i(6'h08, 5'd0, 5'd0, 16'd5);
      dut.d1.r_imem[1] = enc_i(6'h08, 5'd0, 5'd1, 16'hFFFF);
      dut.d1.r_imem[2] = enc_i(6'h08, 5'd0, 5'd2, 16'd1);
      dut.d1.r_imem[3] = enc_r(6'h2A, 5'd1, 5'd2, 5'd3);
      dut.d1.r_imem[4] = enc_r(6'h2A, 5'd2, 5'd1, 5'd4);
      dut.d1.r_imem[5] = 32'hFC22_0001;
      do_reset();
      tick();
      checks++; if (dut.d1.instruction_registers.register[0] !== 16'd0) begin failures++; $display("FAIL zero_reg got=%0d exp=0", dut.d1.instruction_registers.register[0]); end
      tick();
      tick();
      checks++; if ({out, alu_op_out} !== {16'd1, 3'b100}) begin failures++; $display("FAIL slt_neg got=%h exp=%h", {out, alu_op_out}, {16'd1, 3'b100}); end
      tick();
      tick();
      checks++; if ({reg_write_en_out, mem_write_en_out} !== 2'b00) begin failures++; $display("FAIL unknown_nop got=%b exp=00", {reg_write_en_out, mem_write_en_out}); end
      checks++; if ({dut.d1.instruction_registers.register[3], dut.d1.instruction_registers.register[4]} !== {16'd1, 16'd0}) begin failures++; $display("FAIL slt_regs got=%h exp=00010000", {dut.d1.instruction_registers.register[3], dut.d1.instruction_registers.register[4]}); end
      tick();
      checks++; if (dut.d1.r_pc !== 8'd6) begin failures++; $display("FAIL nop_pc got=%0d exp=6", dut.d1.r_pc); end
   endtask

   initial begin
      test_reset();
      test_sub();
      test_lw_sw();
      test_branch();
      test_jump();
      test_mult();
      test_reset_mid_mult();
      test_zero_slt();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
